// File: rtl/gpio_pio_ctrl.sv
// Avalon-MM GPIO controller: per-bit direction, synchronised inputs, atomic
// set/clear of outputs, edge capture with write-1-to-clear and a maskable irq.
module gpio_pio_ctrl #(
    parameter int          WIDTH     = 8,
    parameter int          EDGE_TYPE = 0,
    parameter logic [31:0] RESET_OUT = 32'h0000_0000
) (
    input  logic             csi_clk,
    input  logic             rsi_reset,
    input  logic             avs_s0_chipselect,
    input  logic [2:0]       avs_s0_address,
    input  logic             avs_s0_read,
    input  logic             avs_s0_write,
    input  logic [31:0]      avs_s0_writedata,
    output logic [31:0]      avs_s0_readdata,
    input  logic [WIDTH-1:0] coe_gpio_in,
    output logic [WIDTH-1:0] coe_gpio_out,
    output logic [WIDTH-1:0] coe_gpio_oe,
    output logic             ins_irq0_irq
);

    localparam logic [2:0] ADDR_OUT  = 3'd0;
    localparam logic [2:0] ADDR_DIR  = 3'd1;
    localparam logic [2:0] ADDR_IN   = 3'd2;
    localparam logic [2:0] ADDR_MASK = 3'd3;
    localparam logic [2:0] ADDR_EDGE = 3'd4;
    localparam logic [2:0] ADDR_SET  = 3'd5;
    localparam logic [2:0] ADDR_CLR  = 3'd6;

    logic [WIDTH-1:0] out_r;
    logic [WIDTH-1:0] dir_r;
    logic [WIDTH-1:0] mask_r;
    logic [WIDTH-1:0] edge_cap_r;
    logic [WIDTH-1:0] s1_r;
    logic [WIDTH-1:0] s2_r;
    logic [WIDTH-1:0] prev_r;
    logic [1:0]       arm_cnt_r;
    logic [31:0]      readdata_r;
    logic             irq_r;

    logic             wr_s;
    logic             rd_s;
    logic [WIDTH-1:0] wd_s;
    logic [WIDTH-1:0] edge_raw_s;
    logic [WIDTH-1:0] det_s;
    logic [WIDTH-1:0] w1c_s;
    logic [WIDTH-1:0] out_nxt_s;
    logic [WIDTH-1:0] dir_nxt_s;
    logic [WIDTH-1:0] mask_nxt_s;
    logic [WIDTH-1:0] cap_nxt_s;
    logic [31:0]      rdata_s;
    logic             unused_wd_s;

    assign wr_s        = avs_s0_chipselect & avs_s0_write;
    assign rd_s        = avs_s0_chipselect & avs_s0_read;
    assign wd_s        = avs_s0_writedata[WIDTH-1:0];
    assign unused_wd_s = ^avs_s0_writedata;

    // Edge select; suppressed until the synchroniser holds post-reset samples
    always_comb begin
        case (EDGE_TYPE)
            32'sd0:  edge_raw_s = s2_r & ~prev_r;
            32'sd1:  edge_raw_s = ~s2_r & prev_r;
            default: edge_raw_s = s2_r ^ prev_r;
        endcase
        if (arm_cnt_r == 2'd3) begin
            det_s = edge_raw_s;
        end else begin
            det_s = {WIDTH{1'b0}};
        end
    end

    // Register write decode; a new edge beats a simultaneous W1C on the same bit
    always_comb begin
        out_nxt_s  = out_r;
        dir_nxt_s  = dir_r;
        mask_nxt_s = mask_r;
        w1c_s      = {WIDTH{1'b0}};
        if (wr_s) begin
            case (avs_s0_address)
                ADDR_OUT:  out_nxt_s  = wd_s;
                ADDR_DIR:  dir_nxt_s  = wd_s;
                ADDR_MASK: mask_nxt_s = wd_s;
                ADDR_EDGE: w1c_s      = wd_s;
                ADDR_SET:  out_nxt_s  = out_r | wd_s;
                ADDR_CLR:  out_nxt_s  = out_r & ~wd_s;
                default:   out_nxt_s  = out_r;
            endcase
        end else begin
            w1c_s = {WIDTH{1'b0}};
        end
        cap_nxt_s = (edge_cap_r & ~w1c_s) | det_s;
    end

    // Read mux, zero-extended to the bus width
    always_comb begin
        rdata_s = 32'h0000_0000;
        case (avs_s0_address)
            ADDR_OUT:  rdata_s[WIDTH-1:0] = out_r;
            ADDR_DIR:  rdata_s[WIDTH-1:0] = dir_r;
            ADDR_IN:   rdata_s[WIDTH-1:0] = s2_r;
            ADDR_MASK: rdata_s[WIDTH-1:0] = mask_r;
            ADDR_EDGE: rdata_s[WIDTH-1:0] = edge_cap_r;
            default:   rdata_s            = 32'h0000_0000;
        endcase
    end

    // Input synchroniser, edge history and arm counter
    always_ff @(posedge csi_clk or posedge rsi_reset) begin
        if (rsi_reset) begin
            s1_r      <= {WIDTH{1'b0}};
            s2_r      <= {WIDTH{1'b0}};
            prev_r    <= {WIDTH{1'b0}};
            arm_cnt_r <= 2'd0;
        end else begin
            s1_r   <= coe_gpio_in;
            s2_r   <= s1_r;
            prev_r <= s2_r;
            if (arm_cnt_r != 2'd3) begin
                arm_cnt_r <= arm_cnt_r + 2'd1;
            end else begin
                arm_cnt_r <= arm_cnt_r;
            end
        end
    end

    // Control registers, read data and irq (irq built from next-state flops)
    always_ff @(posedge csi_clk or posedge rsi_reset) begin
        if (rsi_reset) begin
            out_r      <= RESET_OUT[WIDTH-1:0];
            dir_r      <= {WIDTH{1'b0}};
            mask_r     <= {WIDTH{1'b0}};
            edge_cap_r <= {WIDTH{1'b0}};
            readdata_r <= 32'h0000_0000;
            irq_r      <= 1'b0;
        end else begin
            out_r      <= out_nxt_s;
            dir_r      <= dir_nxt_s;
            mask_r     <= mask_nxt_s;
            edge_cap_r <= cap_nxt_s;
            readdata_r <= rd_s ? rdata_s : 32'h0000_0000;
            irq_r      <= |(cap_nxt_s & mask_nxt_s);
        end
    end

    assign avs_s0_readdata = readdata_r;
    assign coe_gpio_out    = out_r;
    assign coe_gpio_oe     = dir_r;
    assign ins_irq0_irq    = irq_r;

endmodule

// File: tb/tb_gpio_pio_ctrl.sv
// Bench for gpio_pio_ctrl: three instances (rising, falling, any edge) on one
// shared bus, compared every cycle against a pin-history reference model.
module tb_gpio_pio_ctrl;

    logic        clk;
    logic        rst;
    logic        cs;
    logic [2:0]  addr;
    logic        rd;
    logic        wr;
    logic [31:0] wd;
    logic [7:0]  gin0, gin1, gin2;
    logic [31:0] rdata0, rdata1, rdata2;
    logic [7:0]  gout0, gout1, gout2;
    logic [7:0]  goe0, goe1, goe2;
    logic        irq0, irq1, irq2;

    int n_total = 0;
    int n_pass  = 0;

    gpio_pio_ctrl #(.WIDTH(8), .EDGE_TYPE(0), .RESET_OUT(32'h0000_00A5)) dut0 (
        .csi_clk(clk), .rsi_reset(rst), .avs_s0_chipselect(cs), .avs_s0_address(addr),
        .avs_s0_read(rd), .avs_s0_write(wr), .avs_s0_writedata(wd), .avs_s0_readdata(rdata0),
        .coe_gpio_in(gin0), .coe_gpio_out(gout0), .coe_gpio_oe(goe0), .ins_irq0_irq(irq0));

    gpio_pio_ctrl #(.WIDTH(8), .EDGE_TYPE(1), .RESET_OUT(32'h0000_003C)) dut1 (
        .csi_clk(clk), .rsi_reset(rst), .avs_s0_chipselect(cs), .avs_s0_address(addr),
        .avs_s0_read(rd), .avs_s0_write(wr), .avs_s0_writedata(wd), .avs_s0_readdata(rdata1),
        .coe_gpio_in(gin1), .coe_gpio_out(gout1), .coe_gpio_oe(goe1), .ins_irq0_irq(irq1));

    gpio_pio_ctrl #(.WIDTH(8), .EDGE_TYPE(2), .RESET_OUT(32'h0000_0000)) dut2 (
        .csi_clk(clk), .rsi_reset(rst), .avs_s0_chipselect(cs), .avs_s0_address(addr),
        .avs_s0_read(rd), .avs_s0_write(wr), .avs_s0_writedata(wd), .avs_s0_readdata(rdata2),
        .coe_gpio_in(gin2), .coe_gpio_out(gout2), .coe_gpio_oe(goe2), .ins_irq0_irq(irq2));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: register contents plus the full list of pin samples
    // taken at each clock edge since the last reset.
    localparam int HMAX = 2048;
    logic [7:0]  m_out  [3];
    logic [7:0]  m_dir  [3];
    logic [7:0]  m_mask [3];
    logic [7:0]  m_cap  [3];
    logic [31:0] m_rd   [3];
    logic        m_irq  [3];
    logic [7:0]  hist   [3][HMAX];
    int          hlen   [3];
    int          m_etype[3] = '{0, 1, 2};
    logic [7:0]  m_rstout[3] = '{8'hA5, 8'h3C, 8'h00};

    function automatic logic [7:0] pin_of(input int i);
        case (i)
            0:       return gin0;
            1:       return gin1;
            default: return gin2;
        endcase
    endfunction

    task automatic mreset(input int i);
        m_out[i]  = m_rstout[i];
        m_dir[i]  = 8'h00;
        m_mask[i] = 8'h00;
        m_cap[i]  = 8'h00;
        m_rd[i]   = 32'h0;
        m_irq[i]  = 1'b0;
        hlen[i]   = 0;
    endtask

    function automatic logic [31:0] mread(input int i, input logic [2:0] a);
        logic [7:0] v;
        case (a)
            3'd0:    v = m_out[i];
            3'd1:    v = m_dir[i];
            3'd2:    v = (hlen[i] >= 2) ? hist[i][hlen[i]-2] : 8'h00;
            3'd3:    v = m_mask[i];
            3'd4:    v = m_cap[i];
            default: v = 8'h00;
        endcase
        return {24'h0, v};
    endfunction

    task automatic mstep(input int i);
        logic [7:0] det, cur, old, d8;
        det = 8'h00;
        m_rd[i] = (cs && rd) ? mread(i, addr) : 32'h0;
        // The pin seen two samples ago is compared with the one three samples ago
        if (hlen[i] >= 3) begin
            cur = hist[i][hlen[i]-2];
            old = hist[i][hlen[i]-3];
            for (int b = 0; b < 8; b++) begin
                if (cur[b] != old[b]) begin
                    if (m_etype[i] == 2 || (m_etype[i] == 0 && cur[b]) || (m_etype[i] == 1 && !cur[b]))
                        det[b] = 1'b1;
                end
            end
        end
        d8 = wd[7:0];
        if (cs && wr) begin
            case (addr)
                3'd0: m_out[i]  = d8;
                3'd1: m_dir[i]  = d8;
                3'd3: m_mask[i] = d8;
                3'd4: m_cap[i]  = m_cap[i] & ~d8;
                3'd5: m_out[i]  = m_out[i] | d8;
                3'd6: m_out[i]  = m_out[i] & ~d8;
                default: ;
            endcase
        end
        m_cap[i] = m_cap[i] | det;
        m_irq[i] = |(m_cap[i] & m_mask[i]);
        if (hlen[i] < HMAX) begin
            hist[i][hlen[i]] = pin_of(i);
            hlen[i]++;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic check_all();
        chk("rd0", rdata0, m_rd[0]);  chk("out0", {24'h0, gout0}, {24'h0, m_out[0]});
        chk("oe0", {24'h0, goe0}, {24'h0, m_dir[0]});  chk("irq0", {31'h0, irq0}, {31'h0, m_irq[0]});
        chk("rd1", rdata1, m_rd[1]);  chk("out1", {24'h0, gout1}, {24'h0, m_out[1]});
        chk("oe1", {24'h0, goe1}, {24'h0, m_dir[1]});  chk("irq1", {31'h0, irq1}, {31'h0, m_irq[1]});
        chk("rd2", rdata2, m_rd[2]);  chk("out2", {24'h0, gout2}, {24'h0, m_out[2]});
        chk("oe2", {24'h0, goe2}, {24'h0, m_dir[2]});  chk("irq2", {31'h0, irq2}, {31'h0, m_irq[2]});
    endtask

    // One clock: model follows the edge, outputs are compared on the falling edge
    task automatic tick();
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            if (rst) mreset(i);
            else     mstep(i);
        end
        @(negedge clk);
        check_all();
    endtask

    task automatic op(input logic r, input logic w, input logic [2:0] a, input logic [31:0] d);
        cs = r | w; rd = r; wr = w; addr = a; wd = d;
        tick();
        cs = 1'b0; rd = 1'b0; wr = 1'b0;
    endtask

    initial begin
        rst = 1'b1; cs = 1'b0; rd = 1'b0; wr = 1'b0; addr = 3'd0; wd = 32'h0;
        gin0 = 8'hFF; gin1 = 8'h00; gin2 = 8'hFF;
        for (int i = 0; i < 3; i++) mreset(i);
        tick();
        tick();
        chk("rst_out", {24'h0, gout0}, 32'h0000_00A5);
        chk("rst_oe", {24'h0, goe0}, 32'h0);
        chk("rst_irq", {31'h0, irq0}, 32'h0);
        chk("rst_rd", rdata0, 32'h0);
        rst = 1'b0;

        // Pins held high through reset must not register an edge
        op(1'b0, 1'b1, 3'd3, 32'h0000_00FF);
        repeat (20) tick();
        op(1'b1, 1'b0, 3'd4, 32'h0);
        chk("arm_cap0", rdata0, 32'h0);
        chk("arm_irq0", {31'h0, irq0}, 32'h0);
        chk("arm_cap2", rdata2, 32'h0);

        op(1'b1, 1'b0, 3'd0, 32'h0);
        chk("rd_out_a5", rdata0, 32'h0000_00A5);
        op(1'b0, 1'b1, 3'd0, 32'h0000_000F);
        chk("out_0f", {24'h0, gout0}, 32'h0000_000F);
        op(1'b0, 1'b1, 3'd5, 32'h0000_00F0);
        chk("outset_ff", {24'h0, gout0}, 32'h0000_00FF);
        op(1'b0, 1'b1, 3'd6, 32'h0000_003C);
        chk("outclr_c3", {24'h0, gout0}, 32'h0000_00C3);
        op(1'b0, 1'b1, 3'd0, 32'hFFFF_FF00);
        op(1'b1, 1'b0, 3'd0, 32'h0);
        chk("out_upper_drop", rdata0, 32'h0);
        op(1'b0, 1'b1, 3'd1, 32'h0000_005A);
        chk("dir_5a", {24'h0, goe0}, 32'h0000_005A);

        // Pin 3 falls then rises
        gin0 = 8'hF7; tick(); gin0 = 8'hFF;
        repeat (4) tick();
        op(1'b1, 1'b0, 3'd4, 32'h0);
        chk("pin3_cap", rdata0, 32'h0000_0008);
        op(1'b0, 1'b1, 3'd4, 32'h0000_0008);

        // Rising edge latency on pin 0
        op(1'b0, 1'b1, 3'd3, 32'h0000_0001);
        gin0 = 8'hFE; repeat (3) tick();
        gin0 = 8'hFF;
        tick();
        chk("lat_irq_n", {31'h0, irq0}, 32'h0);
        tick();
        chk("lat_irq_n1", {31'h0, irq0}, 32'h0);
        tick();
        chk("lat_irq_n2", {31'h0, irq0}, 32'h1);
        op(1'b1, 1'b0, 3'd4, 32'h0);
        chk("lat_cap_n3", rdata0, 32'h0000_0001);
        op(1'b0, 1'b1, 3'd4, 32'h0000_0001);
        chk("w1c_irq_low", {31'h0, irq0}, 32'h0);

        // W1C landing on the same edge as a new capture
        gin0 = 8'hFE; repeat (3) tick();
        gin0 = 8'hFF; tick(); tick();
        op(1'b0, 1'b1, 3'd4, 32'h0000_0001);
        chk("coin_irq", {31'h0, irq0}, 32'h1);
        op(1'b1, 1'b0, 3'd4, 32'h0);
        chk("coin_cap", rdata0, 32'h0000_0001);
        op(1'b0, 1'b1, 3'd4, 32'h0000_00FF);

        // Any-edge instance, mask applied after capture
        op(1'b0, 1'b1, 3'd3, 32'h0);
        gin2 = 8'h7F;
        repeat (4) tick();
        op(1'b1, 1'b0, 3'd4, 32'h0);
        chk("any_cap", rdata2, 32'h0000_0080);
        chk("any_irq_masked", {31'h0, irq2}, 32'h0);
        op(1'b0, 1'b1, 3'd3, 32'h0000_0080);
        chk("any_irq_on", {31'h0, irq2}, 32'h1);

        // Asynchronous reset between clock edges
        #2 rst = 1'b1;
        #1;
        chk("mid_out0", {24'h0, gout0}, 32'h0000_00A5);
        chk("mid_oe0", {24'h0, goe0}, 32'h0);
        chk("mid_irq2", {31'h0, irq2}, 32'h0);
        chk("mid_out1", {24'h0, gout1}, 32'h0000_003C);
        for (int i = 0; i < 3; i++) mreset(i);
        tick();
        tick();
        rst = 1'b0;

        // Random traffic and pin activity
        for (int k = 0; k < 400; k++) begin
            cs   = ($urandom_range(0, 4) != 0);
            rd   = $urandom_range(0, 1);
            wr   = ($urandom_range(0, 2) == 0);
            addr = 3'($urandom_range(0, 7));
            wd   = $urandom;
            if ($urandom_range(0, 2) == 0) gin0 = 8'($urandom);
            if ($urandom_range(0, 2) == 0) gin1 = 8'($urandom);
            if ($urandom_range(0, 2) == 0) gin2 = 8'($urandom);
            if (k == 200) rst = 1'b1;
            if (k == 203) rst = 1'b0;
            tick();
        end
        cs = 1'b0; rd = 1'b0; wr = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/gpio_pio_ctrl.md
# gpio_pio_ctrl

Parametrised Avalon-MM general-purpose I/O controller. Provides a WIDTH-bit bidirectional port with per-bit output enable, synchronised input sampling, atomic set/clear of output bits, edge capture with write-1-to-clear, and a maskable level interrupt. It sits on the Platform Designer fabric as a memory-mapped slave. It is the successor to the fixed 8-bit LED register block and drives LEDs, switches and buttons from one instance type.

## Interface
Parameters:
- WIDTH, 8, number of GPIO bits (1..32); register bits above WIDTH-1 read 0 and ignore writes
- EDGE_TYPE, 0, edge capture mode: 0 rising, 1 falling, 2 any
- RESET_OUT, 0, reset value of OUT register (low WIDTH bits used)

Ports:
- csi_clk  in  1  clock
- rsi_reset  in  1  reset; reset rsi_reset, asynchronous, active-high; clock csi_clk
- avs_s0_chipselect  in  1  slave select
- avs_s0_address  in  3  word address
- avs_s0_read  in  1  read strobe
- avs_s0_write  in  1  write strobe
- avs_s0_writedata  in  32  write data
- avs_s0_readdata  out  32  registered read data, read latency 1
- coe_gpio_in  in  WIDTH  asynchronous pin inputs
- coe_gpio_out  out  WIDTH  output values (= OUT register)
- coe_gpio_oe  out  WIDTH  per-bit output enable (= DIR register, 1 = drive)
- ins_irq0_irq  out  1  level interrupt, active-high

## Operation
- Access qualified by chipselect; write = chipselect & write, read = chipselect & read. Read and write in the same cycle: both act, and the read returns the pre-write value.
- Register map (word address):
  - 0 OUT, RW
  - 1 DIR, RW
  - 2 IN, RO: synchronised pin value; writes ignored
  - 3 IRQ_MASK, RW
  - 4 EDGE_CAP, R / W1C
  - 5 OUTSET, WO: OUT |= wd; reads 0
  - 6 OUTCLR, WO: OUT &= ~wd; reads 0
  - 7 reserved: reads 0, writes ignored
- Input path: two-flop synchroniser (s1, s2), then history flop prev <= s2. IN reads s2.
- Edge detect per bit:
  - rise = s2 & ~prev
  - fall = ~s2 & prev
  - any = s2 ^ prev
  - selected by EDGE_TYPE
- Edge arming: a 2-bit counter starts at 0 on reset and increments each cycle until saturating at 3. Edge detect is gated off while count < 3, so a pin held high through reset never produces a spurious capture.
- EDGE_CAP next state = (EDGE_CAP & ~w1c_mask) | detected. If a W1C and a new edge hit the same bit in the same cycle, the set wins.
- ins_irq0_irq = |(EDGE_CAP & IRQ_MASK), decoded from flops only (glitch-free).
- Reset values:
  - OUT = RESET_OUT[WIDTH-1:0]
  - DIR, IRQ_MASK, EDGE_CAP, s1, s2, prev, arm counter = 0
  - avs_s0_readdata = 0, ins_irq0_irq = 0
- Reset asserted mid-operation returns every register to its reset value immediately (asynchronous). The arm counter restarts.

## Timing
- Write: the register updates at the write edge. coe_gpio_out and coe_gpio_oe show the new value in the cycle after that edge.
- Read: read sampled at edge R. readdata holds the register value as of just before edge R, from after R until the next read edge. readdata returns to 0 after any edge with no read.
- Input latency: a pin stable before edge N gives s1 at N and s2 at N+1. A read sampled at N+2 returns the new value.
- Edge capture: a pin transition stable before edge N sets EDGE_CAP at N+2. The irq (if masked in) is high after N+2.
- W1C to EDGE_CAP at edge W clears the bit after W. The irq deasserts after W if no other masked bit remains set.
- A pulse shorter than one clock period may be missed; the minimum detectable pulse is 1 full cycle high and 1 cycle low.
- OUTSET and OUTCLR are single-cycle atomic read-modify-write with no bus stall.

## Test plan
- Reset with RESET_OUT=8'hA5, WIDTH=8 -> coe_gpio_out=A5, coe_gpio_oe=00, irq=0, readdata=0; read addr 0 -> 0x000000A5 one cycle after the read edge.
- Write OUT=0x0F, OUTSET 0xF0, then OUTCLR 0x3C -> coe_gpio_out goes 0F, FF, C3 on consecutive cycles; write 0xFFFFFF00 to OUT -> reads back 0x00000000 (upper bits dropped).
- EDGE_TYPE=0, IRQ_MASK=0x01, pin0 0->1 at edge N -> EDGE_CAP reads 0x01 from a read at N+3, irq high after N+2; W1C 0x01 -> irq low next cycle.
- Coin-hit: W1C bit 0 in the same cycle a new rising edge is detected on bit 0 -> EDGE_CAP bit 0 stays 1 and irq stays high.
- coe_gpio_in=0xFF held through reset release, EDGE_TYPE=0 -> EDGE_CAP stays 0 and irq stays 0 for 20 cycles; then pin3 falls and rises -> EDGE_CAP=0x08.
- EDGE_TYPE=2, mask 0x00, toggle pin 7 -> EDGE_CAP=0x80 with irq=0; set mask 0x80 -> irq high after the write edge; assert rsi_reset mid-sequence -> all outputs at reset values immediately.
